// File: rtl/clk_monitor.sv
// Frequency checker: counts synchronized rising edges of mon_clk over a fixed
// window of clk cycles and runs an acquire/lock/fault state machine on the result.
module clk_monitor #(
  parameter int WINDOW       = 1000,
  parameter int EXP_COUNT    = 250,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mon_clk,
  input  logic          enable,
  input  logic          fault_clr,
  output logic [CW-1:0] count,
  output logic          count_valid,
  output logic          locked,
  output logic          fault,
  output logic [1:0]    state_dbg
);

  localparam int WW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int LO_I = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
  localparam int HI_I = EXP_COUNT + TOL;
  localparam logic [CW:0] LO = (CW+1)'(LO_I);
  localparam logic [CW:0] HI = (CW+1)'(HI_I);

  typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_FAULT} state_e;

  state_e        state_q, state_d;
  logic [2:0]    sync_q, sync_d;
  logic [WW-1:0] win_q, win_d;
  logic [CW-1:0] edge_q, edge_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [3:0]    run_q, run_d;
  logic          fault_q, fault_d;

  logic          edge_det;
  logic          terminal;
  logic          good;
  logic [CW-1:0] edge_inc;
  logic [CW:0]   cnt_ext;
  logic [3:0]    run_inc;

  // sync_q[0] and sync_q[1] form the two-flop synchronizer; sync_q[2] delays for edge detect
  assign edge_det = sync_q[1] & ~sync_q[2];
  assign terminal = enable && (win_q == WW'(WINDOW - 1));
  assign edge_inc = (edge_det && (edge_q != '1)) ? edge_q + CW'(1) : edge_q;
  assign cnt_ext  = {1'b0, edge_inc};
  assign good     = (cnt_ext >= LO) && (cnt_ext <= HI);
  assign run_inc  = run_q + 4'd1;

  always_comb begin
    sync_d  = {sync_q[1:0], mon_clk};
    state_d = state_q;
    win_d   = win_q;
    edge_d  = edge_q;
    count_d = count_q;
    valid_d = 1'b0;
    run_d   = run_q;
    fault_d = fault_q;

    if (fault_clr) fault_d = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      win_d   = '0;
      edge_d  = '0;
      run_d   = '0;
    end else begin
      if (terminal) begin
        win_d   = '0;
        edge_d  = '0;
        count_d = edge_inc;
        valid_d = 1'b1;
      end else begin
        win_d  = win_q + WW'(1);
        edge_d = edge_inc;
      end

      unique case (state_q)
        S_IDLE:    state_d = S_ACQUIRE;
        S_ACQUIRE: begin
          if (terminal) begin
            if (good) begin
              run_d = run_inc;
              if (run_inc >= 4'(LOCK_WINDOWS)) state_d = S_LOCKED;
            end else begin
              run_d = '0;
            end
          end
        end
        S_LOCKED: begin
          // A bad window overrides a simultaneous fault_clr
          if (terminal && !good) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state_d = S_ACQUIRE;
            run_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      win_q   <= '0;
      edge_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      count_q <= count_d;
      valid_q <= valid_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign locked      = (state_q == S_LOCKED);
  assign fault       = fault_q;
  assign state_dbg   = state_q;

endmodule
